// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter between pipeline writeback and multi-cycle unit
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK_WbArb,
    input  logic        RST_WbArb,
    input  logic        WB_Valid,
    input  logic [4:0]  WB_Addr,
    input  logic [31:0] WB_Data,
    input  logic        MD_Req,
    input  logic [4:0]  MD_Addr,
    input  logic [31:0] MD_Data,
    output logic        MD_Ack,
    input  logic [4:0]  RdAddr1,
    input  logic [4:0]  RdAddr2,
    output logic        Pend_Hit1,
    output logic        Pend_Hit2,
    output logic        Stall_Pipe,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_inc;
    logic       w_supersede;
    logic       w_md_denied;

    // A same-address WB write is younger than the MD result, so the MD request is acked and dropped
    assign w_supersede = WB_Valid && MD_Req && (WB_Addr == MD_Addr) && (MD_Addr != 5'd0);
    assign MD_Ack      = RST_WbArb && MD_Req && (!WB_Valid || w_supersede);
    assign w_md_denied = MD_Req && !MD_Ack;
    assign w_cnt_inc   = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;

    assign Stall_Pipe = (r_state == STALL);
    assign Pend_Hit1  = RST_WbArb && (RdAddr1 != 5'd0) &&
                        ((MD_Req && (MD_Addr == RdAddr1)) || (WE3 && (A3 == RdAddr1)));
    assign Pend_Hit2  = RST_WbArb && (RdAddr2 != 5'd0) &&
                        ((MD_Req && (MD_Addr == RdAddr2)) || (WE3 && (A3 == RdAddr2)));

    always_ff @(posedge CLK_WbArb or negedge RST_WbArb) begin
        if (!RST_WbArb) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A request that is granted or withdrawn always restarts starvation counting from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_md_denied) begin
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = (4'd1 >= LIMIT) ? STALL : WAIT;
                end else begin
                    w_cnt_nxt = 4'd0;
                end
            end
            WAIT, STALL: begin
                if (w_md_denied) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc >= LIMIT) ? STALL : WAIT;
                end else begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_WbArb or negedge RST_WbArb) begin
        if (!RST_WbArb) begin
            WE3 <= 1'b0;
            A3  <= 5'd0;
            WD3 <= 32'd0;
        end else if (WB_Valid) begin
            WE3 <= (WB_Addr != 5'd0);
            A3  <= WB_Addr;
            WD3 <= WB_Data;
        end else if (MD_Req) begin
            WE3 <= (MD_Addr != 5'd0);
            A3  <= MD_Addr;
            WD3 <= MD_Data;
        end else begin
            WE3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_req;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ack;
    logic [4:0]  rd1, rd2;
    logic        hit1, hit2;
    logic        stall;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [4:0]  last_a;
    logic [31:0] last_d;
    int          n_cmp;
    int          n_err;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK_WbArb (clk),
        .RST_WbArb (rst_n),
        .WB_Valid  (wb_valid),
        .WB_Addr   (wb_addr),
        .WB_Data   (wb_data),
        .MD_Req    (md_req),
        .MD_Addr   (md_addr),
        .MD_Data   (md_data),
        .MD_Ack    (md_ack),
        .RdAddr1   (rd1),
        .RdAddr2   (rd2),
        .Pend_Hit1 (hit1),
        .Pend_Hit2 (hit2),
        .Stall_Pipe(stall),
        .A3        (a3),
        .WD3       (wd3),
        .WE3       (we3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests at the falling edge and queue the write it should produce
    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        wr_t e;
        @(negedge clk);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        md_req   = mv; md_addr = ma; md_data = md;
        if (wv)      begin e.we = (wa != 5'd0); e.a = wa; e.d = wd; end
        else if (mv) begin e.we = (ma != 5'd0); e.a = ma; e.d = md; end
        else         begin e.we = 1'b0; e.a = last_a; e.d = last_d; end
        last_a = e.a;
        last_d = e.d;
        sb.push_back(e);
        #1;
    endtask

    task automatic step(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_we"}, 32'(we3), 32'(e.we));
            chk({tag, "_a3"}, 32'(a3), 32'(e.a));
            chk({tag, "_wd3"}, wd3, e.d);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        last_a = 5'd0; last_d = 32'd0;
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_1111;
        md_req = 1'b1; md_addr = 5'd3; md_data = 32'h2222_2222;
        rd1 = 5'd3; rd2 = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we3), 32'd0);
        chk("rst_a3", 32'(a3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ack", 32'(md_ack), 32'd0);
        chk("rst_hit1", 32'(hit1), 32'd0);
        @(negedge clk);
        wb_valid = 1'b0; md_req = 1'b0;
        rst_n = 1'b1;

        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        chk("wb_ack", 32'(md_ack), 32'd0);
        step("wb5");
        rd1 = 5'd5;
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h1234_5678);
        chk("wb_pend_hit1", 32'(hit1), 32'd1);
        rd2 = 5'd9;
        #0 chk("md_ack", 32'(md_ack), 32'd1);
        chk("md_pend_hit2", 32'(hit2), 32'd1);
        step("md9");
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step("idle_hold");

        for (int i = 1; i <= 6; i++) begin
            drive(1, 5'(i), 32'hA000_0000 + 32'(i), 1, 5'd12, 32'hC0FF_EE12);
            chk($sformatf("starve_stall_c%0d", i), 32'(stall), (i >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("starve_ack_c%0d", i), 32'(md_ack), 32'd0);
            step($sformatf("starve_wr_c%0d", i));
        end
        drive(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0FF_EE12);
        chk("starve_release_ack", 32'(md_ack), 32'd1);
        chk("starve_release_stall", 32'(stall), 32'd1);
        step("starve_md_wr");
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("starve_stall_clear", 32'(stall), 32'd0);
        step("starve_idle");

        drive(1, 5'd7, 32'hAAAA_AAAA, 1, 5'd7, 32'hBBBB_BBBB);
        chk("same_addr_ack", 32'(md_ack), 32'd1);
        step("same_addr_wb");
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step("same_addr_no_md");
        chk("same_addr_stall", 32'(stall), 32'd0);

        rd1 = 5'd0;
        drive(1, 5'd0, 32'h5555_0000, 0, 5'd0, 32'd0);
        step("wb_addr0");
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h6666_0000);
        chk("md_addr0_ack", 32'(md_ack), 32'd1);
        chk("addr0_pend_hit1", 32'(hit1), 32'd0);
        step("md_addr0");

        for (int i = 0; i < 2; i++) begin
            drive(1, 5'd1, 32'h7700_0000 + 32'(i), 1, 5'd13, 32'h1313_1313);
            step("drop_pre");
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step("drop_idle");
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'd2, 32'h8800_0000 + 32'(i), 1, 5'd13, 32'h1313_1313);
            chk($sformatf("drop_restart_stall_c%0d", i), 32'(stall), 32'd0);
            step("drop_restart");
        end
        drive(1, 5'd2, 32'h8800_0005, 1, 5'd13, 32'h1313_1313);
        chk("drop_restart_stalled", 32'(stall), 32'd1);
        chk("stall_we3_pre_rst", 32'(we3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        last_a = 5'd0; last_d = 32'd0;
        chk("async_rst_we", 32'(we3), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_a3", 32'(a3), 32'd0);
        chk("async_rst_wd3", wd3, 32'd0);
        chk("async_rst_ack", 32'(md_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'd3, 32'h9900_0000 + 32'(i), 1, 5'd13, 32'h1313_1313);
            chk($sformatf("post_rst_stall_c%0d", i), 32'(stall), 32'd0);
            step("post_rst");
        end
        drive(0, 5'd0, 32'd0, 1, 5'd13, 32'h1313_1313);
        chk("post_rst_ack", 32'(md_ack), 32'd1);
        step("post_rst_md_wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
